// File: rtl/ellipse_buf_pkg.sv
// Shared constants for the ellipse rasteriser pixel buffers (serial-to-parallel and back).
package ellipse_buf_pkg;

   localparam int unsigned GROUP_SIZE     = 4;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_DEPTH      = 64;
   localparam int unsigned DEF_LOG2DEPTH  = 6;

endpackage

// File: rtl/ellipse_buffer_in_if.sv
// Handshake bundle for ellipse_buffer_in: single-word producer side and 4-lane consumer side.
// ELLIPSE_BUF_IN_LAST_EN adds in_last / out_mask for short end-of-primitive groups.
interface ellipse_buffer_in_if #(
   parameter int unsigned DATA_WIDTH = ellipse_buf_pkg::DEF_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_rts;
   logic                  in_rtr;
   logic [DATA_WIDTH-1:0] out_px_0;
   logic [DATA_WIDTH-1:0] out_px_1;
   logic [DATA_WIDTH-1:0] out_px_2;
   logic [DATA_WIDTH-1:0] out_px_3;
   logic                  out_rts;
   logic                  out_rtr;
`ifdef ELLIPSE_BUF_IN_LAST_EN
   logic                  in_last;
   logic [3:0]            out_mask;

   modport master (output in_data, in_rts, in_last, out_rtr,
                   input  in_rtr, out_px_0, out_px_1, out_px_2, out_px_3, out_rts, out_mask);
   modport slave  (input  in_data, in_rts, in_last, out_rtr,
                   output in_rtr, out_px_0, out_px_1, out_px_2, out_px_3, out_rts, out_mask);
`else
   modport master (output in_data, in_rts, out_rtr,
                   input  in_rtr, out_px_0, out_px_1, out_px_2, out_px_3, out_rts);
   modport slave  (input  in_data, in_rts, out_rtr,
                   output in_rtr, out_px_0, out_px_1, out_px_2, out_px_3, out_rts);
`endif
endinterface

// File: rtl/ellipse_buf_ram.sv
// Queue storage: one write port, GROUP_SIZE combinational read ports at rd_addr+0..3 (wrapping).
module ellipse_buf_ram
   import ellipse_buf_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned LOG2DEPTH = DEF_LOG2DEPTH
) (
   input  logic                                  clk,
   input  logic                                  we,
   input  logic [LOG2DEPTH-1:0]                  wr_addr,
   input  logic [WIDTH-1:0]                      wr_data,
   input  logic [LOG2DEPTH-1:0]                  rd_addr,
   output logic [GROUP_SIZE-1:0][WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[wr_addr] <= wr_data;
   end

   // Address addition wraps naturally at the power-of-2 depth.
   always_comb begin
      for (int k = 0; k < GROUP_SIZE; k++) begin
         rd_data[k] = mem_q[rd_addr + LOG2DEPTH'(k)];
      end
   end

endmodule

// File: rtl/ellipse_buffer_in.sv
// Serial-to-parallel elastic buffer: one pixel word in per handshake, groups of 4 out.
// ELLIPSE_BUF_IN_LAST_EN enables variable 1-4 word groups terminated by in_last.
module ellipse_buffer_in
   import ellipse_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned LOG2DEPTH  = DEF_LOG2DEPTH
) (
   input  logic                clk,
   input  logic                rst_,
   ellipse_buffer_in_if.slave  bus
);

   localparam int unsigned CNT_W = LOG2DEPTH + 1;
`ifdef ELLIPSE_BUF_IN_LAST_EN
   localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
   localparam int unsigned WORD_W = DATA_WIDTH;
`endif

   logic [LOG2DEPTH-1:0]              wr_addr_q, wr_addr_d;
   logic [LOG2DEPTH-1:0]              rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]                  count_q, count_d;
   logic                              in_rtr_q, in_rtr_d;
   logic                              in_xfc, out_xfc, out_rts;
   logic [CNT_W-1:0]                  adv;
   logic [WORD_W-1:0]                 wr_word;
   logic [GROUP_SIZE-1:0][WORD_W-1:0] rd_word;

   ellipse_buf_ram #(
      .WIDTH     (WORD_W),
      .DEPTH     (DEPTH),
      .LOG2DEPTH (LOG2DEPTH)
   ) u_ram (
      .clk     (clk),
      .we      (in_xfc),
      .wr_addr (wr_addr_q),
      .wr_data (wr_word),
      .rd_addr (rd_addr_q),
      .rd_data (rd_word)
   );

`ifdef ELLIPSE_BUF_IN_LAST_EN
   logic [2:0] grp_n;
   logic       short_grp;

   assign wr_word = {bus.in_last, bus.in_data};

   // First valid lane carrying last ends the group; otherwise a full group of 4.
   always_comb begin
      grp_n     = 3'd4;
      short_grp = 1'b0;
      for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
         if ((CNT_W'(k) < count_q) && rd_word[k][DATA_WIDTH]) begin
            grp_n     = 3'(k + 1);
            short_grp = 1'b1;
         end
      end
   end

   assign out_rts      = (count_q >= CNT_W'(GROUP_SIZE)) | short_grp;
   assign adv          = CNT_W'(grp_n);
   assign bus.out_mask = 4'((5'd1 << grp_n) - 5'd1);
`else
   logic out_rts_q, out_rts_d;

   assign wr_word   = bus.in_data;
   assign adv       = CNT_W'(GROUP_SIZE);
   assign out_rts   = out_rts_q;
   assign out_rts_d = (count_d >= CNT_W'(GROUP_SIZE));

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) out_rts_q <= 1'b0;
      else       out_rts_q <= out_rts_d;
   end
`endif

   // Pointer and occupancy update; in and out transfers may coincide.
   always_comb begin
      in_xfc    = bus.in_rts & in_rtr_q;
      out_xfc   = out_rts & bus.out_rtr;
      wr_addr_d = wr_addr_q + LOG2DEPTH'(in_xfc);
      rd_addr_d = out_xfc ? (rd_addr_q + LOG2DEPTH'(adv)) : rd_addr_q;
      count_d   = count_q + CNT_W'(in_xfc) - (out_xfc ? adv : CNT_W'(0));
      in_rtr_d  = (count_d != CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         count_q   <= '0;
         in_rtr_q  <= 1'b1;
      end else begin
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         count_q   <= count_d;
         in_rtr_q  <= in_rtr_d;
      end
   end

   assign bus.in_rtr   = in_rtr_q;
   assign bus.out_rts  = out_rts;
   assign bus.out_px_0 = rd_word[0][DATA_WIDTH-1:0];
   assign bus.out_px_1 = rd_word[1][DATA_WIDTH-1:0];
   assign bus.out_px_2 = rd_word[2][DATA_WIDTH-1:0];
   assign bus.out_px_3 = rd_word[3][DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ellipse_buffer_in.sv
// Directed bench for ellipse_buffer_in: vector table plus fill, streaming-wrap and reset sequences.
module tb_ellipse_buffer_in;

   localparam int DW    = 32;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst_;
   logic last_v = 1'b0;

   always #5 clk = ~clk;

   ellipse_buffer_in_if #(.DATA_WIDTH(DW)) bus ();

   ellipse_buffer_in #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .LOG2DEPTH  (6)
   ) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rts;
      logic [31:0] data;
      logic        rtr;
      logic        exp_in_rtr;
      logic        exp_out_rts;
      logic        chk_px;
      logic [31:0] px0, px1, px2, px3;
   } vec_t;

   vec_t vecs[10];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rts, input logic [31:0] d, input logic rtr);
      bus.in_rts  = rts;
      bus.in_data = d;
      bus.out_rtr = rtr;
`ifdef ELLIPSE_BUF_IN_LAST_EN
      bus.in_last = last_v;
`endif
   endtask

   // Apply the currently driven inputs across one edge, then settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0);
      rst_ = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   task automatic chk_group(input string name, input logic [31:0] b);
      chk32({name, " px0"}, bus.out_px_0, b);
      chk32({name, " px1"}, bus.out_px_1, b + 32'd1);
      chk32({name, " px2"}, bus.out_px_2, b + 32'd2);
      chk32({name, " px3"}, bus.out_px_3, b + 32'd3);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   sent, got, cnt;
      logic rts_v, rtr_v, in_x, out_x;

      // {rts, data, out_rtr, in_rtr after edge, out_rts after edge, check lanes, px0..px3}
      vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[3] = '{1'b0, 32'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[4] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44};
      vecs[5] = '{1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[6] = '{1'b1, 32'h66, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[7] = '{1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};
      vecs[8] = '{1'b1, 32'h88, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 32'h66, 32'h77, 32'h88};
      vecs[9] = '{1'b0, 32'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0};

      do_reset();
      #1;
      chk1("reset in_rtr", bus.in_rtr, 1'b1);
      chk1("reset out_rts", bus.out_rts, 1'b0);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].rts, vecs[i].data, vecs[i].rtr);
         step();
         chk1($sformatf("vec%0d in_rtr", i), bus.in_rtr, vecs[i].exp_in_rtr);
         chk1($sformatf("vec%0d out_rts", i), bus.out_rts, vecs[i].exp_out_rts);
         if (vecs[i].chk_px) begin
            chk32($sformatf("vec%0d px0", i), bus.out_px_0, vecs[i].px0);
            chk32($sformatf("vec%0d px1", i), bus.out_px_1, vecs[i].px1);
            chk32($sformatf("vec%0d px2", i), bus.out_px_2, vecs[i].px2);
            chk32($sformatf("vec%0d px3", i), bus.out_px_3, vecs[i].px3);
         end
         @(negedge clk);
      end

      // Fill to full with the consumer stalled, then release one group.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 1'b0);
         step();
         if (i == DEPTH - 2) chk1("fill in_rtr at 63", bus.in_rtr, 1'b1);
         @(negedge clk);
      end
      chk1("full in_rtr", bus.in_rtr, 1'b0);
      chk1("full out_rts", bus.out_rts, 1'b1);
      drive(1'b1, 32'hDEAD, 1'b0);
      step();
      chk1("full held in_rtr", bus.in_rtr, 1'b0);
      chk_group("full head", 32'h100);
      @(negedge clk);
      drive(1'b1, 32'hBEEF, 1'b1);
      step();
      chk1("after pop in_rtr", bus.in_rtr, 1'b1);
      chk_group("after pop head", 32'h104);
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, 32'h200 + 32'(j), 1'b0);
         step();
         chk1($sformatf("refill %0d in_rtr", j), bus.in_rtr, j != 3);
         @(negedge clk);
      end

      // Random stalls; pointers wrap several times over 200 words.
      do_reset();
      sent = 0;
      got  = 0;
      cnt  = 0;
      for (int cyc = 0; cyc < 4000 && got < 200; cyc++) begin
         rts_v = (sent < 200) && ($urandom_range(0, 3) != 0);
         rtr_v = ($urandom_range(0, 2) != 0);
         drive(rts_v, 32'(sent), rtr_v);
         #1;
         chk1("stream in_rtr", bus.in_rtr, cnt != DEPTH);
         chk1("stream out_rts", bus.out_rts, cnt >= 4);
         in_x  = rts_v && (cnt != DEPTH);
         out_x = rtr_v && (cnt >= 4);
         if (out_x) begin
            chk_group("stream group", 32'(got));
            got += 4;
         end
         if (in_x) sent++;
         if (in_x) cnt++;
         if (out_x) cnt -= 4;
         @(negedge clk);
      end
      chk32("stream words consumed", 32'(got), 32'd200);

      // Asynchronous reset with 10 words queued.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h300 + 32'(i), 1'b0);
         step();
         @(negedge clk);
      end
      chk1("pre-reset out_rts", bus.out_rts, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      #2;
      rst_ = 1'b0;
      #1;
      chk1("async reset in_rtr", bus.in_rtr, 1'b1);
      chk1("async reset out_rts", bus.out_rts, 1'b0);
      @(negedge clk);
      rst_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h400 + 32'(i), 1'b0);
         step();
         chk1($sformatf("post-reset push%0d out_rts", i), bus.out_rts, i == 3);
         @(negedge clk);
      end
      chk_group("post-reset group", 32'h400);

`ifdef ELLIPSE_BUF_IN_LAST_EN
      // Short group terminated by last, then a full group starting two entries on.
      do_reset();
      last_v = 1'b0;
      drive(1'b1, 32'hA, 1'b0);
      step();
      chk1("last A out_rts", bus.out_rts, 1'b0);
      @(negedge clk);
      last_v = 1'b1;
      drive(1'b1, 32'hB, 1'b0);
      step();
      chk1("last B out_rts", bus.out_rts, 1'b1);
      chk32("last B mask", 32'(bus.out_mask), 32'h3);
      chk32("last B px0", bus.out_px_0, 32'hA);
      chk32("last B px1", bus.out_px_1, 32'hB);
      @(negedge clk);
      last_v = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      step();
      chk1("short drain out_rts", bus.out_rts, 1'b0);
      chk1("short drain in_rtr", bus.in_rtr, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hC + 32'(i), 1'b0);
         step();
         @(negedge clk);
      end
      chk1("after short out_rts", bus.out_rts, 1'b1);
      chk32("after short mask", 32'(bus.out_mask), 32'hF);
      chk_group("after short group", 32'hC);
`endif

      drive(1'b0, 32'h0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
